// File: rtl/obi_mem_responder.sv
// obi_mem_responder: behavioural OBI slave for the simulation/formal harness.
// A small word-addressed memory is accessed at grant time. Each granted
// transaction is queued in an in-order response FIFO that ages every cycle.
// External stall inputs delay grants and responses, but the produced bus
// traffic is always legal.
module obi_mem_responder #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int RSP_LATENCY     = 1,
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_WORDS       = 256
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   req_i,
  output logic                                   gnt_o,
  input  logic [ADDR_WIDTH-1:0]                  addr_i,
  input  logic                                   we_i,
  input  logic [3:0]                             be_i,
  input  logic [31:0]                            wdata_i,
  output logic                                   rvalid_o,
  output logic [31:0]                            rdata_o,
  input  logic                                   gnt_stall_i,
  input  logic                                   rvalid_stall_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   protocol_err_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int AGE_W = $clog2(RSP_LATENCY + 1);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(RSP_LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  // Backing store; cleared by reset, so it is kept in flops rather than RAM.
  logic [31:0] mem_reg [MEM_WORDS];

  // Response FIFO entry views, driven from the per-entry generate blocks.
  logic [MAX_OUTSTANDING-1:0] ent_valid;
  logic [AGE_W-1:0]           ent_age   [MAX_OUTSTANDING];
  logic [31:0]                ent_rdata [MAX_OUTSTANDING];

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  // Request-stability tracker state.
  logic                  hold_pending_reg;
  logic [ADDR_WIDTH-1:0] hold_addr_reg;
  logic                  hold_we_reg;
  logic [3:0]            hold_be_reg;
  logic [31:0]           hold_wdata_reg;
  logic                  err_reg;

  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      rd_word;
  logic [31:0]      wr_word;
  logic             push;
  logic             pop;
  logic             head_ready;
  logic             req_changed;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Upper address bits beyond the index are dropped, so accesses wrap.
  assign mem_idx = addr_i[IDX_W+1:2];
  assign rd_word = mem_reg[mem_idx];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_word[8*gi +: 8] = be_i[gi] ? wdata_i[8*gi +: 8] : rd_word[8*gi +: 8];
    end
  endgenerate

  // Grant has no same-cycle bypass: a full FIFO refuses even if the head retires now.
  assign gnt_o = rst_ni & req_i & ~gnt_stall_i & (count_reg < CNT_MAX);
  assign push  = req_i & gnt_o;

  assign head_ready = ent_valid[head_reg] & (ent_age[head_reg] >= AGE_MAX);
  assign rvalid_o   = rst_ni & head_ready & ~rvalid_stall_i;
  assign rdata_o    = rvalid_o ? ent_rdata[head_reg] : 32'h0;
  assign pop        = rvalid_o;

  assign outstanding_o  = count_reg;
  assign protocol_err_o = err_reg;

  assign req_changed = (addr_i != hold_addr_reg) | (we_i != hold_we_reg) |
                       (be_i != hold_be_reg) | (wdata_i != hold_wdata_reg);

  // Memory update: byte-lane merge of granted writes, full clear on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push && we_i) begin
      mem_reg[mem_idx] <= wr_word;
    end
  end

  generate
    for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_entry
      logic             valid_reg;
      logic [AGE_W-1:0] age_reg;
      logic [31:0]      rdata_reg;

      assign ent_valid[gi] = valid_reg;
      assign ent_age[gi]   = age_reg;
      assign ent_rdata[gi] = rdata_reg;

      // Entry slot: load on push, free on pop, otherwise age up to the latency.
      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          valid_reg <= 1'b0;
          age_reg   <= '0;
          rdata_reg <= '0;
        end else if (push && (tail_reg == PTR_W'(gi))) begin
          valid_reg <= 1'b1;
          age_reg   <= AGE_W'(1);
          rdata_reg <= we_i ? 32'h0 : rd_word;
        end else if (pop && (head_reg == PTR_W'(gi))) begin
          valid_reg <= 1'b0;
          age_reg   <= '0;
        end else if (valid_reg && (age_reg < AGE_MAX)) begin
          age_reg <= age_reg + AGE_W'(1);
        end
      end
    end
  endgenerate

  // FIFO pointers and the registered outstanding count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= next_ptr(tail_reg);
      end
      if (pop) begin
        head_reg <= next_ptr(head_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Stability tracker: a refused request must be held unchanged; violations latch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_pending_reg <= 1'b0;
      hold_addr_reg    <= '0;
      hold_we_reg      <= 1'b0;
      hold_be_reg      <= '0;
      hold_wdata_reg   <= '0;
      err_reg          <= 1'b0;
    end else begin
      hold_pending_reg <= req_i & ~gnt_o;
      hold_addr_reg    <= addr_i;
      hold_we_reg      <= we_i;
      hold_be_reg      <= be_i;
      hold_wdata_reg   <= wdata_i;
      if (hold_pending_reg && (!req_i || req_changed)) begin
        err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder (MAX_OUTSTANDING=2, RSP_LATENCY=1).
// Per-cycle vectors hold inputs and hand-computed expected outputs; reset and
// protocol-error corner cases are written out as explicit sequences.
module tb_obi_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        gnt_stall;
  logic        rvalid_stall;
  logic [1:0]  outstanding;
  logic        perr;

  int checks;
  int failures;

  obi_mem_responder #(
    .MAX_OUTSTANDING(2),
    .RSP_LATENCY    (1),
    .ADDR_WIDTH     (32),
    .MEM_WORDS      (256)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .gnt_o         (gnt),
    .addr_i        (addr),
    .we_i          (we),
    .be_i          (be),
    .wdata_i       (wdata),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .gnt_stall_i   (gnt_stall),
    .rvalid_stall_i(rvalid_stall),
    .outstanding_o (outstanding),
    .protocol_err_o(perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gstall;
    logic        rstall;
    logic        exp_gnt;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_out;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [31:0] a, input logic w,
                              input logic [3:0] b, input logic [31:0] d,
                              input logic gs, input logic rs, input logic eg,
                              input logic ev, input logic [31:0] ed,
                              input logic [1:0] eo);
    vec_t v;
    v.req = r; v.addr = a; v.we = w; v.be = b; v.wdata = d;
    v.gstall = gs; v.rstall = rs;
    v.exp_gnt = eg; v.exp_rvalid = ev; v.exp_rdata = ed; v.exp_out = eo;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d,
                       input logic gs, input logic rs);
    req = r; addr = a; we = w; be = b; wdata = d;
    gnt_stall = gs; rvalid_stall = rs;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset while an entry is queued and a request is pending.
    drive(1'b1, 32'h8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    #2;
    check("pre_gnt", 0, 32'(gnt), 32'h1);
    $display("reset_seq: queue read at 0x8 gnt=%0d", gnt);
    tick();
    drive(1'b0, 32'h8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1);
    #2;
    check("pre_out", 1, 32'(outstanding), 32'h1);
    check("pre_rvalid", 1, 32'(rvalid), 32'h0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 32'h8, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #2;
      check("rst_gnt", 2 + i, 32'(gnt), 32'h0);
      check("rst_rvalid", 2 + i, 32'(rvalid), 32'h0);
      check("rst_rdata", 2 + i, rdata, 32'h0);
      if (i == 1) check("rst_out", 2 + i, 32'(outstanding), 32'h0);
      $display("reset_seq: reset cycle %0d gnt=%0d rvalid=%0d out=%0d", i, gnt, rvalid, outstanding);
      tick();
    end
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #2;
      check("post_rst_rvalid", 4 + i, 32'(rvalid), 32'h0);
      check("post_rst_out", 4 + i, 32'(outstanding), 32'h0);
      check("post_rst_err", 4 + i, 32'(perr), 32'h0);
      $display("reset_seq: after release rvalid=%0d out=%0d", rvalid, outstanding);
      tick();
    end

    // Per-cycle vector table.
    //              req addr          we  be     wdata         gs rs  gnt rv rdata         out
    vecs.push_back(mk(1, 32'h10,  1, 4'b0101, 32'hAABBCCDD, 0, 0,  1, 0, 32'h0,        2'd0));
    vecs.push_back(mk(1, 32'h10,  0, 4'hF,    32'h0,        0, 0,  1, 1, 32'h0,        2'd1));
    vecs.push_back(mk(0, 32'h0,   0, 4'hF,    32'h0,        0, 0,  0, 1, 32'h00BB00DD, 2'd1));
    vecs.push_back(mk(1, 32'h0,   1, 4'hF,    32'h11223344, 0, 0,  1, 0, 32'h0,        2'd0));
    vecs.push_back(mk(1, 32'h400, 0, 4'hF,    32'h0,        0, 0,  1, 1, 32'h0,        2'd1));
    vecs.push_back(mk(0, 32'h0,   0, 4'hF,    32'h0,        0, 0,  0, 1, 32'h11223344, 2'd1));
    vecs.push_back(mk(0, 32'h0,   0, 4'hF,    32'h0,        0, 0,  0, 0, 32'h0,        2'd0));
    // back-to-back reads with responses stalled; third waits for the first pop
    vecs.push_back(mk(1, 32'h10,  0, 4'hF,    32'h0,        0, 1,  1, 0, 32'h0,        2'd0));
    vecs.push_back(mk(1, 32'h0,   0, 4'hF,    32'h0,        0, 1,  1, 0, 32'h0,        2'd1));
    vecs.push_back(mk(1, 32'h4,   0, 4'hF,    32'h0,        0, 1,  0, 0, 32'h0,        2'd2));
    vecs.push_back(mk(1, 32'h4,   0, 4'hF,    32'h0,        0, 0,  0, 1, 32'h00BB00DD, 2'd2));
    vecs.push_back(mk(1, 32'h4,   0, 4'hF,    32'h0,        0, 0,  1, 1, 32'h11223344, 2'd1));
    vecs.push_back(mk(0, 32'h0,   0, 4'hF,    32'h0,        0, 0,  0, 1, 32'h0,        2'd1));
    vecs.push_back(mk(0, 32'h0,   0, 4'hF,    32'h0,        0, 0,  0, 0, 32'h0,        2'd0));
    // read then write to the same word: read returns the pre-write value
    vecs.push_back(mk(1, 32'h10,  0, 4'hF,    32'h0,        0, 1,  1, 0, 32'h0,        2'd0));
    vecs.push_back(mk(1, 32'h10,  1, 4'hF,    32'h12345678, 0, 1,  1, 0, 32'h0,        2'd1));
    vecs.push_back(mk(0, 32'h0,   0, 4'hF,    32'h0,        0, 0,  0, 1, 32'h00BB00DD, 2'd2));
    vecs.push_back(mk(0, 32'h0,   0, 4'hF,    32'h0,        0, 0,  0, 1, 32'h0,        2'd1));
    vecs.push_back(mk(1, 32'h10,  0, 4'hF,    32'h0,        0, 0,  1, 0, 32'h0,        2'd0));
    vecs.push_back(mk(0, 32'h0,   0, 4'hF,    32'h0,        0, 0,  0, 1, 32'h12345678, 2'd1));
    vecs.push_back(mk(0, 32'h0,   0, 4'hF,    32'h0,        0, 0,  0, 0, 32'h0,        2'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata,
            vecs[i].gstall, vecs[i].rstall);
      #2;
      check("gnt", 100 + i, 32'(gnt), 32'(vecs[i].exp_gnt));
      check("rvalid", 100 + i, 32'(rvalid), 32'(vecs[i].exp_rvalid));
      check("rdata", 100 + i, rdata, vecs[i].exp_rdata);
      check("outstanding", 100 + i, 32'(outstanding), 32'(vecs[i].exp_out));
      check("perr_clean", 100 + i, 32'(perr), 32'h0);
      $display("vec %0d: req=%0d we=%0d addr=0x%0h gnt=%0d rvalid=%0d rdata=0x%08h out=%0d",
               i, req, we, addr, gnt, rvalid, rdata, outstanding);
      tick();
    end

    // Protocol violation: a refused request changes its address.
    drive(1'b1, 32'h20, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    #2;
    check("perr_gnt_stalled", 200, 32'(gnt), 32'h0);
    check("perr_before", 200, 32'(perr), 32'h0);
    tick();
    drive(1'b1, 32'h24, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);
    #2;
    check("perr_same_cycle", 201, 32'(perr), 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      check("perr_sticky", 202 + i, 32'(perr), 32'h1);
      $display("perr_seq: cycle %0d protocol_err=%0d", i, perr);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    check("perr_cleared", 205, 32'(perr), 32'h0);
    $display("perr_seq: after reset protocol_err=%0d", perr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
